matrix_addsub_seq: RTL and testbench

- Parametrised, sequential successor to the team's combinational 5x5 matrix subtractor.
- Adds or subtracts two flattened DIM x DIM matrices, LANES elements per cycle.
- Supports signed/unsigned operands, optional saturation, a runtime active sub-matrix size and a start/busy/done handshake.
- Sits between the matrix operand registers and the result write-back path of the matrix coprocessor.

---
 rtl/matrix_pkg.sv | 23 ++
 rtl/matrix_lane_alu.sv | 42 ++++
 rtl/matrix_addsub_seq.sv | 158 +++++++++++++++
 tb/tb_matrix_addsub_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the matrix add/sub engine.
package matrix_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of LANES-wide chunks needed to cover a dim x dim matrix.
  function automatic int unsigned nchunk(input int unsigned dim, input int unsigned lanes);
    return (dim * dim + lanes - 1) / lanes;
  endfunction

  // A size of 0 or anything above dim selects the full matrix.
  function automatic int unsigned clamp_size(input int unsigned size, input int unsigned dim);
    return ((size == 0) || (size > dim)) ? dim : size;
  endfunction

endpackage

// File: rtl/matrix_lane_alu.sv
// Single-element add/sub with signed/unsigned overflow detection and optional saturation.
module matrix_lane_alu
  import matrix_pkg::*;
#(
  parameter int unsigned EW = 8
) (
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  input  logic          op,
  input  logic          signed_en,
  input  logic          sat_en,
  input  logic          active,
  output logic [EW-1:0] val_c,
  output logic          ovf_c
);

  logic [EW:0]   ext_a;
  logic [EW:0]   ext_b;
  logic [EW:0]   sum;
  logic [EW-1:0] sat_val;
  logic          ovf_raw;

  // One extra bit of headroom; the top two bits reveal over/underflow.
  always_comb begin
    ext_a   = signed_en ? {a[EW-1], a} : {1'b0, a};
    ext_b   = signed_en ? {b[EW-1], b} : {1'b0, b};
    sum     = (op == OP_SUB) ? (ext_a - ext_b) : (ext_a + ext_b);
    ovf_raw = signed_en ? (sum[EW] ^ sum[EW-1]) : sum[EW];
    if (signed_en) begin
      sat_val = sum[EW] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
    end else begin
      sat_val = (op == OP_SUB) ? {EW{1'b0}} : {EW{1'b1}};
    end
    val_c = '0;
    ovf_c = 1'b0;
    if (active) begin
      val_c = (ovf_raw && sat_en) ? sat_val : sum[EW-1:0];
      ovf_c = ovf_raw;
    end
  end

endmodule

// File: rtl/matrix_addsub_seq.sv
// Sequential DIM x DIM matrix add/sub, LANES elements per cycle, with start/busy/done handshake.
module matrix_addsub_seq
  import matrix_pkg::*;
#(
  parameter int unsigned DIM   = 5,
  parameter int unsigned EW    = 8,
  parameter int unsigned LANES = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     op,
  input  logic                     signed_en,
  input  logic                     sat_en,
  input  logic [$clog2(DIM+1)-1:0] size,
  input  logic [DIM*DIM*EW-1:0]    matrix_a,
  input  logic [DIM*DIM*EW-1:0]    matrix_b,
  output logic                     busy,
  output logic                     done,
  output logic [DIM*DIM*EW-1:0]    result,
  output logic                     overflow
);

  localparam int unsigned NEL = DIM * DIM;
  localparam int unsigned MW  = NEL * EW;
  localparam int unsigned NCH = nchunk(DIM, LANES);
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SW  = $clog2(DIM + 1);

  state_t          state_q;
  state_t          state_nxt;
  logic [KW-1:0]   k_q;
  logic [MW-1:0]   a_q;
  logic [MW-1:0]   b_q;
  logic            op_q;
  logic            sgn_q;
  logic            sat_q;
  logic [SW-1:0]   size_q;
  logic [MW-1:0]   result_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;

  logic [MW-1:0]   res_nxt;
  logic            ovf_nxt;
  int unsigned     lane_idx [LANES];
  logic            lane_vld [LANES];
  logic            lane_act [LANES];
  logic [EW-1:0]   lane_a   [LANES];
  logic [EW-1:0]   lane_b   [LANES];
  logic [EW-1:0]   lane_val [LANES];
  logic            lane_ovf [LANES];

  // Route the current chunk's operands to the lanes and decide which elements are in the active square.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_idx[l] = 32'(k_q) * LANES + l;
      lane_vld[l] = lane_idx[l] < NEL;
      lane_a[l]   = '0;
      lane_b[l]   = '0;
      lane_act[l] = 1'b0;
      if (lane_vld[l]) begin
        lane_a[l]   = a_q[lane_idx[l]*EW +: EW];
        lane_b[l]   = b_q[lane_idx[l]*EW +: EW];
        lane_act[l] = ((lane_idx[l] / DIM) < 32'(size_q)) &&
                      ((lane_idx[l] % DIM) < 32'(size_q));
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      matrix_lane_alu #(.EW(EW)) u_alu (
        .a         (lane_a[g]),
        .b         (lane_b[g]),
        .op        (op_q),
        .signed_en (sgn_q),
        .sat_en    (sat_q),
        .active    (lane_act[g]),
        .val_c     (lane_val[g]),
        .ovf_c     (lane_ovf[g])
      );
    end
  endgenerate

  // Merge lane results into the result image; padding lanes past the last element are dropped.
  always_comb begin
    res_nxt = result_q;
    ovf_nxt = ovf_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (lane_vld[l]) begin
        res_nxt[lane_idx[l]*EW +: EW] = lane_val[l];
        ovf_nxt = ovf_nxt | lane_ovf[l];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (k_q == KW'(NCH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand capture, chunk counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      sgn_q    <= 1'b0;
      sat_q    <= 1'b0;
      size_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= (state_nxt == RUN);
      done_q  <= (state_nxt == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= matrix_a;
            b_q      <= matrix_b;
            op_q     <= op;
            sgn_q    <= signed_en;
            sat_q    <= sat_en;
            size_q   <= SW'(clamp_size(32'(size), DIM));
            result_q <= '0;
            ovf_q    <= 1'b0;
            k_q      <= '0;
          end
        end
        RUN: begin
          result_q <= res_nxt;
          ovf_q    <= ovf_nxt;
          k_q      <= (k_q == KW'(NCH - 1)) ? '0 : k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Directed/random bench for matrix_addsub_seq with a queue-based scoreboard and an alternate-parameter instance.
module tb_matrix_addsub_seq;

  localparam int D0 = 5, E0 = 8,  N0 = 5;
  localparam int D1 = 4, E1 = 16, N1 = 6;

  logic         clk, rst_n;
  logic         start0, op0, sgn0, sat0, busy0, done0, ovf0;
  logic [2:0]   size0;
  logic [199:0] a0, b0, result0;
  logic         start1, op1, sgn1, sat1, busy1, done1, ovf1;
  logic [2:0]   size1;
  logic [255:0] a1, b1, result1;

  int checks = 0;
  int errors = 0;

  logic [199:0] exp_res0 [$];
  logic         exp_ovf0 [$];
  logic [255:0] exp_res1 [$];
  logic         exp_ovf1 [$];

  matrix_addsub_seq u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(op0), .signed_en(sgn0), .sat_en(sat0),
    .size(size0), .matrix_a(a0), .matrix_b(b0), .busy(busy0), .done(done0),
    .result(result0), .overflow(ovf0)
  );

  matrix_addsub_seq #(.DIM(4), .EW(16), .LANES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .signed_en(sgn1), .sat_en(sat1),
    .size(size1), .matrix_a(a1), .matrix_b(b1), .busy(busy1), .done(done1),
    .result(result1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Integer reference for one element.
  task automatic ref_elem(input int ew, input logic op, input logic sgn, input logic sat,
                          input longint a, input longint b, output longint v, output logic o);
    longint m, av, bv, r, lo, hi;
    m  = longint'(1) << ew;
    av = a;
    bv = b;
    if (sgn) begin
      if (av >= m / 2) av -= m;
      if (bv >= m / 2) bv -= m;
      lo = -(m / 2);
      hi = m / 2 - 1;
    end else begin
      lo = 0;
      hi = m - 1;
    end
    r = op ? (av - bv) : (av + bv);
    o = (r < lo) || (r > hi);
    v = r;
    if (o && sat) v = (r < lo) ? lo : hi;
    v = v & (m - 1);
  endtask

  task automatic model(input int dim, input int ew, input logic op, input logic sgn, input logic sat,
                       input logic [2:0] sz, input logic [255:0] a, input logic [255:0] b,
                       output logic [255:0] r, output logic o);
    int eff;
    logic [255:0] mask;
    longint v;
    logic eo;
    eff  = (int'(sz) == 0 || int'(sz) > dim) ? dim : int'(sz);
    mask = (256'(1) << ew) - 256'(1);
    r = '0;
    o = 1'b0;
    for (int i = 0; i < dim * dim; i++) begin
      if ((i / dim) < eff && (i % dim) < eff) begin
        ref_elem(ew, op, sgn, sat, longint'((a >> (i * ew)) & mask),
                 longint'((b >> (i * ew)) & mask), v, eo);
        r = r | ((256'(v) & mask) << (i * ew));
        o = o | eo;
      end
    end
  endtask

  task automatic fill0(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < 25; i++) begin
      a0[i*8 +: 8] = av;
      b0[i*8 +: 8] = bv;
    end
  endtask

  // mode 0: plain run; 1: second start + operand change mid-run; 2: reset at T0+3.
  task automatic run0(input string tag, input logic op, input logic sgn, input logic sat,
                      input logic [2:0] sz, input int mode);
    logic [255:0] r;
    logic o;
    logic [199:0] er, res_at_done;
    logic eo, ovf_at_done;
    int busy_cnt, done_cnt, done_at, n;
    @(negedge clk);
    op0 = op; sgn0 = sgn; sat0 = sat; size0 = sz; start0 = 1'b1;
    model(D0, E0, op, sgn, sat, sz, {56'b0, a0}, {56'b0, b0}, r, o);
    exp_res0.push_back(r[199:0]);
    exp_ovf0.push_back(o);
    @(posedge clk);
    #1 start0 = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    res_at_done = '0; ovf_at_done = 1'b0;
    for (n = 0; n < N0 + 10; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (mode == 2 && n == 2) break;
      if (mode == 1 && n == 1) begin
        start0 = 1'b1;
        a0 = ~a0;
        b0 = {b0[191:0], 8'h5a};
        op0 = ~op0;
      end
      if (mode == 1 && n == 3) start0 = 1'b0;
      busy_cnt += int'(busy0);
      if (done0) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          res_at_done = result0;
          ovf_at_done = ovf0;
        end
      end
    end
    er = exp_res0.pop_front();
    eo = exp_ovf0.pop_front();
    if (mode == 2) begin
      #2 rst_n = 1'b0;
      #1;
      chk({tag, " rst busy"}, 64'(busy0), 64'(0));
      chk({tag, " rst done"}, 64'(done0), 64'(0));
      chk({tag, " rst ovf"}, 64'(ovf0), 64'(0));
      checks++;
      assert (result0 === 200'b0) else begin
        errors++;
        $error("FAIL %s rst result: observed %0h expected 0", tag, result0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      repeat (10) begin
        @(posedge clk);
        #1 done_cnt += int'(done0);
      end
      chk({tag, " no done after abort"}, 64'(done_cnt), 64'(0));
    end else begin
      chk({tag, " latency"}, 64'(done_at), 64'(N0));
      chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(N0));
      chk({tag, " done pulses"}, 64'(done_cnt), 64'(1));
      chk({tag, " ovf"}, 64'(ovf_at_done), 64'(eo));
      for (int i = 0; i < 25; i++)
        chk($sformatf("%s el%0d", tag, i), 64'(res_at_done[i*8 +: 8]), 64'(er[i*8 +: 8]));
      checks++;
      assert (result0 === er) else begin
        errors++;
        $error("FAIL %s held result: observed %0h expected %0h", tag, result0, er);
      end
    end
  endtask

  task automatic run1(input string tag);
    logic [255:0] r, er, res_at_done;
    logic o, eo, ovf_at_done;
    int busy_cnt, done_cnt, done_at;
    @(negedge clk);
    start1 = 1'b1;
    model(D1, E1, op1, sgn1, sat1, size1, a1, b1, r, o);
    exp_res1.push_back(r);
    exp_ovf1.push_back(o);
    @(posedge clk);
    #1 start1 = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    res_at_done = '0; ovf_at_done = 1'b0;
    for (int n = 0; n < N1 + 8; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      busy_cnt += int'(busy1);
      if (done1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          res_at_done = result1;
          ovf_at_done = ovf1;
        end
      end
    end
    er = exp_res1.pop_front();
    eo = exp_ovf1.pop_front();
    chk({tag, " latency"}, 64'(done_at), 64'(N1));
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(N1));
    chk({tag, " done pulses"}, 64'(done_cnt), 64'(1));
    chk({tag, " ovf"}, 64'(ovf_at_done), 64'(eo));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s el%0d", tag, i), 64'(res_at_done[i*16 +: 16]), 64'(er[i*16 +: 16]));
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; op0 = 1'b0; sgn0 = 1'b0; sat0 = 1'b0; size0 = 3'd5; a0 = '0; b0 = '0;
    start1 = 1'b0; op1 = 1'b0; sgn1 = 1'b0; sat1 = 1'b0; size1 = 3'd4; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy0), 64'(0));
    chk("reset done", 64'(done0), 64'(0));
    chk("reset ovf", 64'(ovf0), 64'(0));
    chk("reset result lo", result0[63:0], 64'(0));
    chk("reset dut1 busy", 64'(busy1), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    fill0(8'h10, 8'h20);
    run0("legacy sub", 1'b1, 1'b0, 1'b0, 3'd5, 0);
    chk("legacy el0 const", 64'(result0[7:0]), 64'h f0);
    chk("legacy ovf const", 64'(ovf0), 64'(1));

    fill0(8'hf0, 8'h20);
    run0("uadd sat", 1'b0, 1'b0, 1'b1, 3'd5, 0);
    chk("uadd sat el24 const", 64'(result0[199:192]), 64'h ff);
    run0("uadd wrap", 1'b0, 1'b0, 1'b0, 3'd5, 0);
    chk("uadd wrap el12 const", 64'(result0[103:96]), 64'h 10);

    fill0(8'h80, 8'h01);
    run0("ssub sat", 1'b1, 1'b1, 1'b1, 3'd5, 0);
    chk("ssub sat el3 const", 64'(result0[31:24]), 64'h 80);
    fill0(8'h05, 8'h03);
    run0("ssub plain", 1'b1, 1'b1, 1'b1, 3'd5, 0);
    chk("ssub plain ovf const", 64'(ovf0), 64'(0));

    fill0(8'h01, 8'h01);
    run0("size3", 1'b0, 1'b0, 1'b0, 3'd3, 0);
    chk("size3 el0 const", 64'(result0[7:0]), 64'h 02);
    chk("size3 el3 const", 64'(result0[31:24]), 64'h 00);
    chk("size3 el24 const", 64'(result0[199:192]), 64'h 00);
    run0("size0", 1'b0, 1'b0, 1'b0, 3'd0, 0);
    chk("size0 el24 const", 64'(result0[199:192]), 64'h 02);

    fill0(8'h10, 8'h20);
    run0("restart ignored", 1'b1, 1'b0, 1'b0, 3'd5, 1);

    fill0(8'h33, 8'h11);
    run0("abort", 1'b0, 1'b0, 1'b0, 3'd5, 2);
    run0("after abort", 1'b0, 1'b0, 1'b0, 3'd5, 0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 25; i++) begin
        a0[i*8 +: 8] = 8'($urandom);
        b0[i*8 +: 8] = 8'($urandom);
      end
      run0($sformatf("rand%0d", t), 1'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom_range(0, 7)), 0);
    end

    for (int i = 0; i < 16; i++) begin
      a1[i*16 +: 16] = 16'h0001;
      b1[i*16 +: 16] = 16'h0002;
    end
    op1 = 1'b1; sgn1 = 1'b0; sat1 = 1'b1; size1 = 3'd4;
    run1("p4x16 usub sat");
    chk("p4x16 el15 const", 64'(result1[255:240]), 64'h 0000);
    chk("p4x16 ovf const", 64'(ovf1), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
